// File: rtl/pmem_line_responder.sv
// -----------------------------------------------------------------------------
// pmem_line_responder
//
// Memory-side endpoint for the 256-bit cache line interface. One line read or
// write is accepted at a time from IDLE. The response pulses LATENCY cycles
// after the accept, and one recovery cycle follows in which requests are
// ignored. Storage is an internal array of 2**IDX_BITS lines. The array is
// never reset.
//
// Parameters:
//   LATENCY   cycles from accept to pmem_resp (1..255)
//   IDX_BITS  line index width; index = pmem_address[IDX_BITS+4:5]
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   pmem_read     line read request (level, held until pmem_resp)
//   pmem_write    line write request (level, held until pmem_resp)
//   pmem_address  byte address; offset bits and bits above the index ignored
//   pmem_wdata    write line, sampled at accept
//   pmem_rdata    read line, registered, held until the next read completes
//   pmem_resp     one-cycle completion pulse
//   pmem_error    pulses in the accept cycle when read and write are both high
//
// Optional build macro PMEM_STATS_EN:
//   adds read_count / write_count. Each counter increments in the RESPOND cycle
//   of its operation type and wraps at 2**32.
// -----------------------------------------------------------------------------
module pmem_line_responder #(
  parameter int LATENCY  = 4,
  parameter int IDX_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_error
`ifdef PMEM_STATS_EN
  ,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
`endif
);

  localparam int         LINES  = 2 ** IDX_BITS;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [255:0]          wdata_q, wdata_d;
  logic [255:0]          rdata_q, rdata_d;

  logic [255:0]          mem [LINES];

  logic [IDX_BITS-1:0]   addr_idx;
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  rd_load;
  logic                  req;

  // Offset bits and the aliased upper address bits are intentionally dropped.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[31:IDX_BITS+5], pmem_address[4:0]};

  assign addr_idx = pmem_address[IDX_BITS+4:5];
  assign req      = pmem_read | pmem_write;

  // With LATENCY==1 the line is fetched straight out of IDLE, before idx_q
  // has been captured, so the read index comes from the live address.
  assign rd_idx = (state_q == IDLE) ? addr_idx : idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous read and write is resolved as a write.
          op_wr_d = pmem_write;
          idx_d   = addr_idx;
          wdata_d = pmem_wdata;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d = RESPOND;
            rd_load = ~pmem_write;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESPOND;
          rd_load = ~op_wr_q;
        end
      end
      RESPOND: begin
        state_d = RECOVER;
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rd_load) begin
      rdata_d = mem[rd_idx];
    end
  end

  // Control state and the read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Captured request fields; only meaningful while a transaction is in flight
  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // The line is committed on the edge leaving RESPOND. An asynchronous reset
  // forces IDLE first, so an interrupted write never reaches the array.
  always_ff @(posedge clk) begin
    if (state_q == RESPOND && op_wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == RESPOND);
  assign pmem_error = (state_q == IDLE) & pmem_read & pmem_write;

`ifdef PMEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == RESPOND) begin
      if (op_wr_q) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`endif

endmodule
